// File: rtl/sonic_irq_coalescer_if.sv
`default_nettype none
// ============================================================================
// Module      : sonic_irq_coalescer_if
// Description : Shared MSI handshake and prg_reg bus used by the
//               multi-port RX IRQ coalescer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sonic_irq_coalescer_if;
  // MSI side
  logic        msi_sel;
  logic        app_msi_req;
  logic        app_msi_ack;
  logic [4:0]  app_msi_num;
  logic [2:0]  app_msi_tc;
  logic        msi_busy;
  // register bus
  logic        prg_wrena;
  logic [7:0]  prg_addr;
  logic [31:0] prg_wrdata;
  logic [31:0] prg_rddata;

  // The coalescer is the MSI requester and the register target.
  modport master (
    output app_msi_req, app_msi_num, app_msi_tc, msi_busy, prg_rddata,
    input  msi_sel, app_msi_ack, prg_wrena, prg_addr, prg_wrdata
  );

  // PCIe MSI arbiter / register host side.
  modport slave (
    input  app_msi_req, app_msi_num, app_msi_tc, msi_busy, prg_rddata,
    output msi_sel, app_msi_ack, prg_wrena, prg_addr, prg_wrdata
  );
endinterface
`default_nettype wire

// File: rtl/sonic_irq_coalescer.sv
`default_nettype none
// ============================================================================
// Module      : sonic_irq_coalescer
// Description : Per-port RX interrupt coalescing (threshold / timeout) with a
//               round-robin arbiter serialising MSIs onto app_msi.
// Revision    : 1.0 - initial release
// ============================================================================
module sonic_irq_coalescer #(
  parameter int NUM_PORTS    = 2,
  parameter int PTR_WIDTH    = 12,
  parameter int TIMER_WIDTH  = 16,
  parameter int MSI_NUM_BASE = 0
) (
  input  logic                           clk_in,
  input  logic                           rstn,
  input  logic [NUM_PORTS*PTR_WIDTH-1:0] port_wptr,
  input  logic [NUM_PORTS-1:0]           port_enable,
  output logic [NUM_PORTS-1:0]           irq_pending,
  sonic_irq_coalescer_if.master          bus
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // per-port state
  logic [PTR_WIDTH-1:0]   wptr_q     [NUM_PORTS];
  logic [PTR_WIDTH-1:0]   wptr_d     [NUM_PORTS];
  logic [PTR_WIDTH-1:0]   last_ptr_q [NUM_PORTS];
  logic [PTR_WIDTH-1:0]   last_ptr_d [NUM_PORTS];
  logic [PTR_WIDTH-1:0]   outstanding[NUM_PORTS];
  logic [TIMER_WIDTH-1:0] timer_q    [NUM_PORTS];
  logic [TIMER_WIDTH-1:0] timer_d    [NUM_PORTS];
  logic [31:0]            msicnt_q   [NUM_PORTS];
  logic [31:0]            msicnt_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0]   pending_q, pending_d;
  logic [NUM_PORTS-1:0]   trigger;

  // programmable registers
  logic [PTR_WIDTH-1:0]   thresh_q   [NUM_PORTS];
  logic [PTR_WIDTH-1:0]   thresh_d   [NUM_PORTS];
  logic [TIMER_WIDTH-1:0] timeout_q  [NUM_PORTS];
  logic [TIMER_WIDTH-1:0] timeout_d  [NUM_PORTS];
  logic                   msi_enable_q, msi_enable_d;
  logic [2:0]             tc_q, tc_d;
  logic [31:0]            rddata;

  // arbiter
  state_t                 state_q, state_d;
  logic [PORT_W-1:0]      gnt_q, gnt_d;
  logic [PORT_W-1:0]      rr_q, rr_d;
  logic [PTR_WIDTH-1:0]   snap_q, snap_d;
  logic [PORT_W-1:0]      pick_hi, pick_lo, pick;
  logic [PTR_WIDTH-1:0]   snap_hi, snap_lo, snap_pick;
  logic                   found_hi;
  logic                   req, ack_fire;

  logic                   unused_wrdata;
  assign unused_wrdata = ^bus.prg_wrdata;

  // An ack only counts while a request is actually outstanding.
  assign ack_fire = (state_q == ST_REQ) && bus.app_msi_ack;

  // Per-port outstanding count, timer, trigger and pending flag.
  always_comb begin
    trigger = '0;
    pending_d = pending_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wptr_d[p]      = port_wptr[p*PTR_WIDTH +: PTR_WIDTH];
      outstanding[p] = wptr_q[p] - last_ptr_q[p];
      timer_d[p]     = timer_q[p];
      last_ptr_d[p]  = last_ptr_q[p];
      msicnt_d[p]    = msicnt_q[p];
      trigger[p] = port_enable[p] && (outstanding[p] != '0) &&
                   ((outstanding[p] >= ((thresh_q[p] == '0) ? PTR_WIDTH'(1) : thresh_q[p])) ||
                    ((timeout_q[p] != '0) && (timer_q[p] >= timeout_q[p])));
      if (ack_fire && (gnt_q == PORT_W'(p))) begin
        // Service completes: retire entries up to the grant-time snapshot.
        timer_d[p]    = '0;
        last_ptr_d[p] = snap_q;
        msicnt_d[p]   = msicnt_q[p] + 32'd1;
        pending_d[p]  = 1'b0;
      end else begin
        pending_d[p] = pending_q[p] | trigger[p];
        if ((outstanding[p] != '0) && !pending_q[p] && (timer_q[p] != '1))
          timer_d[p] = timer_q[p] + TIMER_WIDTH'(1);
      end
    end
  end

  // Register writes and combinational read-back.
  always_comb begin
    msi_enable_d = msi_enable_q;
    tc_d         = tc_q;
    rddata       = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      thresh_d[p]  = thresh_q[p];
      timeout_d[p] = timeout_q[p];
    end
    if (bus.prg_wrena) begin
      if (bus.prg_addr == 8'h00) begin
        msi_enable_d = bus.prg_wrdata[0];
        tc_d         = bus.prg_wrdata[6:4];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.prg_addr == 8'(8'h10 + 4*p)) thresh_d[p]  = bus.prg_wrdata[PTR_WIDTH-1:0];
        if (bus.prg_addr == 8'(8'h40 + 4*p)) timeout_d[p] = bus.prg_wrdata[TIMER_WIDTH-1:0];
      end
    end
    if (bus.prg_addr == 8'h00) rddata = {25'd0, tc_q, 3'd0, msi_enable_q};
    if (bus.prg_addr == 8'h04) rddata = 32'(pending_q);
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.prg_addr == 8'(8'h10 + 4*p)) rddata = 32'(thresh_q[p]);
      if (bus.prg_addr == 8'(8'h40 + 4*p)) rddata = 32'(timeout_q[p]);
      if (bus.prg_addr == 8'(8'h80 + 4*p)) rddata = msicnt_q[p];
    end
  end

  // Round-robin pick: lowest pending port at/after rr_q, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    snap_hi  = '0;
    snap_lo  = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (pending_q[p]) begin
        pick_lo = PORT_W'(p);
        snap_lo = wptr_q[p];
        if (PORT_W'(p) >= rr_q) begin
          found_hi = 1'b1;
          pick_hi  = PORT_W'(p);
          snap_hi  = wptr_q[p];
        end
      end
    end
    pick      = found_hi ? pick_hi : pick_lo;
    snap_pick = found_hi ? snap_hi : snap_lo;
  end

  // Arbiter next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    snap_d  = snap_q;
    rr_d    = rr_q;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (msi_enable_q && bus.msi_sel && (|pending_q)) begin
          gnt_d   = pick;
          snap_d  = snap_pick;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (bus.app_msi_ack) begin
          rr_d    = (gnt_q == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_q + PORT_W'(1);
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      snap_q  <= snap_d;
    end
  end

  // Per-port and register-file state.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      pending_q    <= '0;
      msi_enable_q <= 1'b0;
      tc_q         <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wptr_q[p]     <= '0;
        last_ptr_q[p] <= '0;
        timer_q[p]    <= '0;
        msicnt_q[p]   <= '0;
        thresh_q[p]   <= '0;
        timeout_q[p]  <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      msi_enable_q <= msi_enable_d;
      tc_q         <= tc_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wptr_q[p]     <= wptr_d[p];
        last_ptr_q[p] <= last_ptr_d[p];
        timer_q[p]    <= timer_d[p];
        msicnt_q[p]   <= msicnt_d[p];
        thresh_q[p]   <= thresh_d[p];
        timeout_q[p]  <= timeout_d[p];
      end
    end
  end

  assign irq_pending     = pending_q;
  assign bus.app_msi_req = req;
  assign bus.msi_busy    = req;
  assign bus.app_msi_num = req ? (5'(MSI_NUM_BASE) + 5'(gnt_q)) : 5'd0;
  assign bus.app_msi_tc  = tc_q;
  assign bus.prg_rddata  = rddata;

endmodule
`default_nettype wire

// File: tb/tb_sonic_irq_coalescer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sonic_irq_coalescer
// Description : Directed self-checking bench for sonic_irq_coalescer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sonic_irq_coalescer;
  localparam int NP = 2;
  localparam int PW = 12;

  logic             clk_in = 1'b0;
  logic             rstn   = 1'b0;
  logic [NP*PW-1:0] port_wptr;
  logic [NP-1:0]    port_enable;
  logic [NP-1:0]    irq_pending;

  int n_checks = 0;
  int n_pass   = 0;

  sonic_irq_coalescer_if bus ();

  sonic_irq_coalescer #(
    .NUM_PORTS(NP), .PTR_WIDTH(PW), .TIMER_WIDTH(16), .MSI_NUM_BASE(0)
  ) dut (
    .clk_in(clk_in), .rstn(rstn), .port_wptr(port_wptr),
    .port_enable(port_enable), .irq_pending(irq_pending), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic set_wptr(input int p, input logic [PW-1:0] v);
    port_wptr[p*PW +: PW] = v;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    bus.prg_addr = a; bus.prg_wrdata = d; bus.prg_wrena = 1'b1;
    @(negedge clk_in);
    bus.prg_wrena = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
    bus.prg_addr = a;
    #1;
    d = bus.prg_rddata;
  endtask

  task automatic wait_req(input int maxc, output int cyc);
    bit done = 0;
    cyc = -1;
    for (int c = 1; c <= maxc && !done; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (bus.app_msi_req === 1'b1) begin cyc = c; done = 1; end
    end
  endtask

  task automatic wait_pend(input int p, input int maxc, output int cyc);
    bit done = 0;
    cyc = -1;
    for (int c = 1; c <= maxc && !done; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (irq_pending[p] === 1'b1) begin cyc = c; done = 1; end
    end
  endtask

  task automatic do_ack();
    bus.app_msi_ack = 1'b1;
    @(negedge clk_in);
    bus.app_msi_ack = 1'b0;
  endtask

  task automatic quiet(input int p, input int n, output bit saw);
    saw = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (bus.app_msi_req || irq_pending[p]) saw = 1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_checks++; if (bus.app_msi_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.app_msi_req); else n_pass++;
    n_checks++; if (bus.msi_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.msi_busy); else n_pass++;
    n_checks++; if (bus.app_msi_num !== 5'd0) $display("FAIL rst_num: got %0d want 0", bus.app_msi_num); else n_pass++;
    n_checks++; if (irq_pending !== 2'b00) $display("FAIL rst_pending: got %b want 00", irq_pending); else n_pass++;
    reg_rd(8'h00, d);
    n_checks++; if (d !== 32'd0) $display("FAIL rst_ctrl: got %h want 0", d); else n_pass++;
    reg_rd(8'h80, d);
    n_checks++; if (d !== 32'd0) $display("FAIL rst_msicnt0: got %h want 0", d); else n_pass++;
    reg_rd(8'h08, d);
    n_checks++; if (d !== 32'd0) $display("FAIL unmapped_rd: got %h want 0", d); else n_pass++;
  endtask

  // THRESH_0=4: wptr 0->4 gives pending 2 cycles and req 3 cycles later.
  task automatic test_threshold();
    logic [31:0] d;
    int pend_c = -1, req_c = -1;
    bit saw;
    port_enable = 2'b01;
    reg_wr(8'h00, 32'h31);
    reg_wr(8'h10, 32'd4);
    reg_rd(8'h10, d);
    n_checks++; if (d !== 32'd4) $display("FAIL thr0_readback: got %0d want 4", d); else n_pass++;
    @(negedge clk_in);
    set_wptr(0, 12'd4);
    for (int c = 1; c <= 10 && req_c < 0; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (pend_c < 0 && irq_pending[0]) pend_c = c;
      if (bus.app_msi_req) req_c = c;
    end
    n_checks++; if (pend_c !== 2) $display("FAIL thr_pend_latency: got %0d want 2", pend_c); else n_pass++;
    n_checks++; if (req_c !== 3) $display("FAIL thr_req_latency: got %0d want 3", req_c); else n_pass++;
    n_checks++; if (bus.app_msi_num !== 5'd0) $display("FAIL thr_num: got %0d want 0", bus.app_msi_num); else n_pass++;
    n_checks++; if (bus.app_msi_tc !== 3'd3) $display("FAIL thr_tc: got %0d want 3", bus.app_msi_tc); else n_pass++;
    n_checks++; if (bus.msi_busy !== 1'b1) $display("FAIL thr_busy: got %b want 1", bus.msi_busy); else n_pass++;
    do_ack();
    n_checks++; if (irq_pending[0] !== 1'b0) $display("FAIL thr_pend_clear: got %b want 0", irq_pending[0]); else n_pass++;
    reg_rd(8'h80, d);
    n_checks++; if (d !== 32'd1) $display("FAIL thr_msicnt0: got %0d want 1", d); else n_pass++;
    quiet(0, 10, saw);
    n_checks++; if (saw !== 1'b0) $display("FAIL thr_no_retrigger: got %b want 0", saw); else n_pass++;
    do_ack();  // stray ack while idle
    reg_rd(8'h80, d);
    n_checks++; if (d !== 32'd1) $display("FAIL idle_ack_ignored: got %0d want 1", d); else n_pass++;
  endtask

  // THRESH_1=100, TIMEOUT_1=50: one entry raises pending after 52 cycles.
  task automatic test_timeout();
    logic [31:0] d;
    int c;
    port_enable = 2'b11;
    reg_wr(8'h14, 32'd100);
    reg_wr(8'h44, 32'd50);
    set_wptr(1, 12'd1);
    wait_pend(1, 80, c);
    n_checks++; if (c !== 52) $display("FAIL tmo_pend_latency: got %0d want 52", c); else n_pass++;
    wait_req(5, c);
    n_checks++; if (c !== 1 || bus.app_msi_num !== 5'd1) $display("FAIL tmo_req: got cyc %0d num %0d want cyc 1 num 1", c, bus.app_msi_num); else n_pass++;
    do_ack();
    reg_rd(8'h84, d);
    n_checks++; if (d !== 32'd1) $display("FAIL tmo_msicnt1: got %0d want 1", d); else n_pass++;
    // timer must restart from zero after the ack
    set_wptr(1, 12'd2);
    wait_pend(1, 80, c);
    n_checks++; if (c !== 52) $display("FAIL tmo_timer_reset: got %0d want 52", c); else n_pass++;
    wait_req(5, c);
    do_ack();
  endtask

  // Both pending with rr at 0: grant 0, then 1, then 0 again.
  task automatic test_back_to_back();
    logic [31:0] d;
    int c;
    bit saw;
    reg_wr(8'h00, 32'h30);
    reg_wr(8'h14, 32'd1);
    reg_wr(8'h44, 32'd0);
    set_wptr(0, 12'd8);
    set_wptr(1, 12'd3);
    quiet(0, 5, saw);
    n_checks++; if (irq_pending !== 2'b11 || bus.app_msi_req !== 1'b0) $display("FAIL dis_retain: got pend %b req %b want 11 0", irq_pending, bus.app_msi_req); else n_pass++;
    reg_rd(8'h04, d);
    n_checks++; if (d !== 32'd3) $display("FAIL pending_reg: got %0d want 3", d); else n_pass++;
    reg_wr(8'h00, 32'h31);
    wait_req(10, c);
    n_checks++; if (c < 0 || bus.app_msi_num !== 5'd0) $display("FAIL rr_first: got cyc %0d num %0d want num 0", c, bus.app_msi_num); else n_pass++;
    do_ack();
    n_checks++; if (bus.app_msi_req !== 1'b0 || bus.msi_busy !== 1'b0) $display("FAIL rr_gap: got req %b busy %b want 0 0", bus.app_msi_req, bus.msi_busy); else n_pass++;
    wait_req(5, c);
    n_checks++; if (c !== 2 || bus.app_msi_num !== 5'd1) $display("FAIL rr_second: got cyc %0d num %0d want cyc 2 num 1", c, bus.app_msi_num); else n_pass++;
    do_ack();
    set_wptr(0, 12'd12);
    wait_req(10, c);
    n_checks++; if (c < 0 || bus.app_msi_num !== 5'd0) $display("FAIL rr_third: got cyc %0d num %0d want num 0", c, bus.app_msi_num); else n_pass++;
    do_ack();
    n_checks++; if (irq_pending !== 2'b00) $display("FAIL rr_all_clear: got %b want 00", irq_pending); else n_pass++;
    reg_rd(8'h84, d);
    n_checks++; if (d !== 32'd3) $display("FAIL rr_msicnt1: got %0d want 3", d); else n_pass++;
  endtask

  // 0xFFE -> 0x001 is 3 entries (below 4), -> 0x002 is 4 across the wrap.
  task automatic test_wrap();
    int c;
    bit saw;
    set_wptr(0, 12'hFFE);
    wait_req(10, c);
    do_ack();
    set_wptr(0, 12'h001);
    quiet(0, 8, saw);
    n_checks++; if (saw !== 1'b0) $display("FAIL wrap_below_thr: got %b want 0", saw); else n_pass++;
    set_wptr(0, 12'h002);
    wait_req(10, c);
    n_checks++; if (c !== 3 || bus.app_msi_num !== 5'd0) $display("FAIL wrap_req: got cyc %0d num %0d want cyc 3 num 0", c, bus.app_msi_num); else n_pass++;
    do_ack();
  endtask

  // Grant snapshot at 0x00A, pointer moves to 0x00E during REQ: 4 remain.
  task automatic test_snapshot();
    logic [31:0] d;
    int c;
    bit saw;
    set_wptr(0, 12'h00A);
    wait_req(10, c);
    set_wptr(0, 12'h00E);
    @(negedge clk_in); @(negedge clk_in);
    n_checks++; if (bus.app_msi_req !== 1'b1) $display("FAIL snap_hold: got %b want 1", bus.app_msi_req); else n_pass++;
    do_ack();
    wait_pend(0, 5, c);
    n_checks++; if (c !== 1) $display("FAIL snap_repend: got %0d want 1", c); else n_pass++;
    wait_req(10, c);
    n_checks++; if (c < 0 || bus.app_msi_num !== 5'd0) $display("FAIL snap_second: got cyc %0d num %0d want num 0", c, bus.app_msi_num); else n_pass++;
    do_ack();
    quiet(0, 8, saw);
    n_checks++; if (saw !== 1'b0) $display("FAIL snap_done: got %b want 0", saw); else n_pass++;
    reg_rd(8'h80, d);
    n_checks++; if (d !== 32'd7) $display("FAIL snap_msicnt0: got %0d want 7", d); else n_pass++;
  endtask

  task automatic test_reset_mid_request();
    logic [31:0] d;
    int c;
    bit saw;
    set_wptr(0, 12'h012);
    wait_req(10, c);
    #2;
    rstn = 1'b0;
    bus.msi_sel = 1'b0;
    #1;
    n_checks++; if (bus.app_msi_req !== 1'b0 || bus.msi_busy !== 1'b0) $display("FAIL rst_async_drop: got req %b busy %b want 0 0", bus.app_msi_req, bus.msi_busy); else n_pass++;
    @(negedge clk_in); @(negedge clk_in);
    rstn = 1'b1;
    reg_rd(8'h00, d);
    n_checks++; if (d !== 32'd0) $display("FAIL rst2_ctrl: got %h want 0", d); else n_pass++;
    reg_rd(8'h10, d);
    n_checks++; if (d !== 32'd0) $display("FAIL rst2_thresh0: got %h want 0", d); else n_pass++;
    reg_rd(8'h80, d);
    n_checks++; if (d !== 32'd0) $display("FAIL rst2_msicnt0: got %h want 0", d); else n_pass++;
    @(negedge clk_in);
    reg_wr(8'h00, 32'h1);
    quiet(0, 10, saw);
    // THRESH 0 acts as 1, so both ports pend; msi_sel low blocks the grant.
    n_checks++; if (irq_pending !== 2'b11 || bus.app_msi_req !== 1'b0) $display("FAIL sel_block: got pend %b req %b want 11 0", irq_pending, bus.app_msi_req); else n_pass++;
    bus.msi_sel = 1'b1;
    wait_req(10, c);
    n_checks++; if (c < 0 || bus.app_msi_num !== 5'd0) $display("FAIL rst2_rr: got cyc %0d num %0d want num 0", c, bus.app_msi_num); else n_pass++;
    do_ack();
  endtask

  initial begin
    bus.msi_sel = 1'b1; bus.app_msi_ack = 1'b0;
    bus.prg_wrena = 1'b0; bus.prg_addr = 8'h00; bus.prg_wrdata = 32'd0;
    port_wptr = '0; port_enable = '0;
    repeat (3) @(negedge clk_in);
    rstn = 1'b1;
    test_reset();
    test_threshold();
    test_timeout();
    test_back_to_back();
    test_wrap();
    test_snapshot();
    test_reset_mid_request();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/sonic_irq_coalescer.md
Name: sonic_irq_coalescer

Overview:
- Multi-port successor to the single-port RX IRQ controller.
- Tracks a ring write pointer for each of NUM_PORTS ports and raises a per-port MSI when either of these is reached:
  - the outstanding-entry count reaches a programmable threshold, or
  - a programmable timeout expires.
- A round-robin arbiter serialises the MSIs onto the shared app_msi interface.
- Sits between the per-port RX DMA engines and the PCIe MSI arbiter; programmed through the standard prg_reg bus.

Parameters:
- NUM_PORTS, 2, number of ports (1..8).
- PTR_WIDTH, 12, ring write-pointer width; arithmetic is modulo 2^PTR_WIDTH.
- TIMER_WIDTH, 16, coalescing timer width in clk_in cycles.
- MSI_NUM_BASE, 0, MSI vector for port 0; port p uses MSI_NUM_BASE+p.

Ports:
- clk_in  in  1  clock
- rstn  in  1  asynchronous active-low reset
- port_wptr  in  NUM_PORTS*PTR_WIDTH  per-port ring write pointers; port p at [p*PTR_WIDTH +: PTR_WIDTH]
- port_enable  in  NUM_PORTS  per-port IRQ enable (enable_sfp per port)
- msi_sel  in  1  shared MSI interface granted to this block
- app_msi_req  out  1  MSI request
- app_msi_ack  in  1  MSI accepted
- app_msi_num  out  5  MSI vector
- app_msi_tc  out  3  traffic class
- msi_busy  out  1  high while a request is in flight
- irq_pending  out  NUM_PORTS  per-port pending flags
- prg_wrena  in  1  register write strobe
- prg_addr  in  8  register byte address
- prg_wrdata  in  32  write data
- prg_rddata  out  32  read data, combinational on prg_addr

Behaviour:
- Reset: all outputs 0; last_ptr, timers, counters and registers 0; arbiter pointer at port 0; FSM in IDLE.
- Reset mid-request drops app_msi_req asynchronously. No ack is expected after reset.
- Registers:
  - 0x00 CTRL (rw): bit0 global msi_enable; bits[6:4] tc, driven onto app_msi_tc.
  - 0x04 PENDING (ro): irq_pending.
  - 0x10+4p THRESH_p (rw): bits[PTR_WIDTH-1:0]; value 0 behaves as 1.
  - 0x40+4p TIMEOUT_p (rw): bits[TIMER_WIDTH-1:0]; value 0 disables the timeout path.
  - 0x80+4p MSICNT_p (ro): 32-bit MSIs sent on port p; wraps.
  - Unmapped reads return 0; writes to ro or unmapped addresses are ignored.
- Per port p, each cycle:
  - wptr_q <= port_wptr slice.
  - outstanding = wptr_q - last_ptr (mod 2^PTR_WIDTH).
  - timer: +1 while outstanding != 0 and not pending; saturates at all-ones; cleared on MSI ack for p.
  - trigger = port_enable[p] & (outstanding != 0) & (outstanding >= THRESH_eff | (TIMEOUT != 0 & timer >= TIMEOUT)).
  - irq_pending[p] set the cycle after trigger; stays set until that port's ack.
- Arbiter FSM:
  - IDLE: if msi_enable & msi_sel & |irq_pending, grant the first pending port at or after rr_ptr (wrapping). Latch gnt and snap_ptr = wptr_q[gnt]; go to REQ.
  - REQ: app_msi_req=1, app_msi_num=MSI_NUM_BASE+gnt, msi_busy=1. Hold until app_msi_ack.
    - On ack: last_ptr[gnt] <= snap_ptr; clear pending[gnt] and timer[gnt]; MSICNT[gnt]++; rr_ptr <= gnt+1 mod NUM_PORTS; go to GAP.
  - GAP: one cycle with app_msi_req=0, msi_busy=0; go to IDLE.
- Latency: port_wptr crossing the threshold at cycle N gives irq_pending at N+2 and app_msi_req at N+3, given IDLE, msi_sel=1 and msi_enable=1.
- Boundaries:
  - Pointer advance during REQ: snapshot semantics apply, so post-grant entries remain outstanding and may retrigger.
  - Pointer wrap: modulo subtraction handles it.
  - outstanding equal to 2^PTR_WIDTH aliases to 0 (software keeps the ring below full).
  - port_enable or msi_enable cleared during REQ: the request completes normally.
  - Cleared msi_enable: pending flags are retained and no new grants are made.
  - app_msi_ack in IDLE or GAP: ignored.
  - THRESH write in the same cycle as a trigger evaluation: the old value is used; the new value applies from the next cycle.
  - A pending port that becomes disabled stays pending until serviced.

Test Plan:
- THRESH_0=4, TIMEOUT_0=0; advance port 0 wptr 0->4 in one step -> app_msi_req 3 cycles later with num=0. Ack -> pending clears, MSICNT_0=1, outstanding=0.
- THRESH_1=100, TIMEOUT_1=50; port 1 wptr 0->1 -> pending after the timer reaches 50, i.e. about 52 cycles later. MSI num=1; timer resets on ack.
- Both ports pending with rr_ptr=0 -> grants in order 0, 1, then 0 again after re-trigger. Each request is separated by exactly one GAP cycle.
- Port 0 wptr 0xFFE->0x002 with THRESH=4 -> outstanding=4 across the wrap, MSI issued.
- During REQ, wptr advances from 8 to 12 with THRESH=4 -> after ack last_ptr=8, pending re-asserts, second MSI issued.
- rstn asserted while app_msi_req=1 -> app_msi_req drops immediately. After release, FSM is IDLE and registers are 0; msi_sel=0 blocks any request.
